// File: rtl/axi4_sha256_periph.sv
`timescale 1ns/1ps
// axi4_sha256_periph: AXI4-lite register front-end for an external SHA-256 core
// (message/digest words, start pulse, status, watchdog). Optional IRQ: SHA_PERIPH_IRQ_EN.
module axi4_sha256_periph #(
    parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
    parameter int unsigned MSG_WORDS  = 16,
    parameter int unsigned HASH_WORDS = 8,
    parameter int unsigned TIMEOUT    = 1024
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      mem_axi_awvalid,
    output logic                      mem_axi_awready,
    input  logic [31:0]               mem_axi_awaddr,
    input  logic [2:0]                mem_axi_awprot,
    input  logic                      mem_axi_wvalid,
    output logic                      mem_axi_wready,
    input  logic [31:0]               mem_axi_wdata,
    input  logic [3:0]                mem_axi_wstrb,
    output logic                      mem_axi_bvalid,
    input  logic                      mem_axi_bready,
    output logic [1:0]                mem_axi_bresp,
    input  logic                      mem_axi_arvalid,
    output logic                      mem_axi_arready,
    input  logic [31:0]               mem_axi_araddr,
    input  logic [2:0]                mem_axi_arprot,
    output logic                      mem_axi_rvalid,
    input  logic                      mem_axi_rready,
    output logic [31:0]               mem_axi_rdata,
    output logic [1:0]                mem_axi_rresp,
    output logic [32*MSG_WORDS-1:0]   core_message,
    output logic                      core_start,
    input  logic                      core_ready,
    input  logic [32*HASH_WORDS-1:0]  core_hash,
    output logic                      irq
);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;
    localparam logic [5:0] W_CTRL   = 6'h00;
    localparam logic [5:0] W_STATUS = 6'h01;
    localparam logic [5:0] W_CYCLES = 6'h02;

    state_t                r_state, w_next_state;
    logic                  r_awready, r_wready, r_arready;
    logic                  r_bvalid, r_rvalid;
    logic [1:0]            r_bresp, r_rresp;
    logic [31:0]           r_rdata;
    logic                  r_aw_full, r_w_full;
    logic [31:0]           r_awaddr, r_wdata;
    logic [3:0]            r_wstrb;
    logic [31:0]           r_msg  [MSG_WORDS];
    logic [31:0]           r_hash [HASH_WORDS];
    logic [31:0]           r_cycles;
    logic                  r_done, r_err, r_core_start;

    logic                  w_aw_hs, w_w_hs, w_ar_hs, w_wr_exec, w_busy;
    logic [5:0]            w_aw_word, w_ar_word;
    logic [1:0]            w_wr_resp, w_rd_resp;
    logic [31:0]           w_rd_data, w_cyc_next;
    logic                  w_ctrl_we, w_start_cmd, w_clr_cmd;
    logic [MSG_WORDS-1:0]  w_msg_we;
    logic                  w_core_done, w_timeout, w_irq_en_rd;
    logic                  w_unused;

    assign mem_axi_awready = r_awready;
    assign mem_axi_wready  = r_wready;
    assign mem_axi_arready = r_arready;
    assign mem_axi_bvalid  = r_bvalid;
    assign mem_axi_bresp   = r_bresp;
    assign mem_axi_rvalid  = r_rvalid;
    assign mem_axi_rdata   = r_rdata;
    assign mem_axi_rresp   = r_rresp;
    assign core_start      = r_core_start;

    assign w_aw_hs   = mem_axi_awvalid & r_awready;
    assign w_w_hs    = mem_axi_wvalid & r_wready;
    assign w_ar_hs   = mem_axi_arvalid & r_arready;
    assign w_wr_exec = r_aw_full & r_w_full & ~r_bvalid;
    assign w_busy    = (r_state == S_RUN);
    assign w_aw_word = r_awaddr[7:2];
    assign w_ar_word = mem_axi_araddr[7:2];
    assign w_unused  = ^{mem_axi_awprot, mem_axi_arprot, r_awaddr[1:0], mem_axi_araddr[1:0]};

    // Write decode: a rejected write (SLVERR/DECERR) raises no enables at all.
    always_comb begin
        w_wr_resp = RESP_OKAY;
        w_ctrl_we = 1'b0;
        w_msg_we  = '0;
        if (r_awaddr[31:8] != BASE_ADDR[31:8]) begin
            w_wr_resp = RESP_DECERR;
        end else if (w_aw_word == W_CTRL) begin
            if (r_wstrb[0]) begin
                if (w_busy && r_wdata[0]) w_wr_resp = RESP_SLVERR;
                else                      w_ctrl_we = 1'b1;
            end
        end else if (w_aw_word == W_STATUS || w_aw_word == W_CYCLES) begin
            w_wr_resp = RESP_SLVERR;
        end else begin
            w_wr_resp = RESP_DECERR;
            for (int unsigned i = 0; i < MSG_WORDS; i++) begin
                if (w_aw_word == 6'(16 + i)) begin
                    if (w_busy) begin
                        w_wr_resp = RESP_SLVERR;
                    end else begin
                        w_wr_resp   = RESP_OKAY;
                        w_msg_we[i] = 1'b1;
                    end
                end
            end
            for (int unsigned i = 0; i < HASH_WORDS; i++) begin
                if (w_aw_word == 6'(32 + i)) w_wr_resp = RESP_SLVERR;
            end
        end
    end

    assign w_start_cmd = w_wr_exec & w_ctrl_we & r_wdata[0];
    assign w_clr_cmd   = w_wr_exec & w_ctrl_we & r_wdata[1];

    always_comb begin
        w_rd_data = '0;
        w_rd_resp = RESP_OKAY;
        if (mem_axi_araddr[31:8] != BASE_ADDR[31:8]) begin
            w_rd_resp = RESP_DECERR;
        end else if (w_ar_word == W_CTRL) begin
            w_rd_data = {29'b0, w_irq_en_rd, 2'b00};
        end else if (w_ar_word == W_STATUS) begin
            w_rd_data = {29'b0, r_err, r_done, w_busy};
        end else if (w_ar_word == W_CYCLES) begin
            w_rd_data = r_cycles;
        end else begin
            w_rd_resp = RESP_DECERR;
            for (int unsigned i = 0; i < MSG_WORDS; i++) begin
                if (w_ar_word == 6'(16 + i)) begin
                    w_rd_data = r_msg[i];
                    w_rd_resp = RESP_OKAY;
                end
            end
            for (int unsigned i = 0; i < HASH_WORDS; i++) begin
                if (w_ar_word == 6'(32 + i)) begin
                    w_rd_data = r_hash[i];
                    w_rd_resp = RESP_OKAY;
                end
            end
        end
    end

    // AW and W are latched independently; the register update happens one edge after both are held.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_aw_full <= 1'b0;
            r_w_full  <= 1'b0;
            r_awaddr  <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_bvalid  <= 1'b0;
            r_bresp   <= RESP_OKAY;
        end else begin
            r_awready <= ~r_awready & mem_axi_awvalid & ~r_aw_full & ~r_bvalid;
            r_wready  <= ~r_wready & mem_axi_wvalid & ~r_w_full & ~r_bvalid;
            if (w_aw_hs) begin
                r_aw_full <= 1'b1;
                r_awaddr  <= mem_axi_awaddr;
            end
            if (w_w_hs) begin
                r_w_full <= 1'b1;
                r_wdata  <= mem_axi_wdata;
                r_wstrb  <= mem_axi_wstrb;
            end
            if (w_wr_exec) begin
                r_aw_full <= 1'b0;
                r_w_full  <= 1'b0;
                r_bvalid  <= 1'b1;
                r_bresp   <= w_wr_resp;
            end else if (r_bvalid && mem_axi_bready) begin
                r_bvalid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rdata   <= '0;
            r_rresp   <= RESP_OKAY;
        end else begin
            r_arready <= ~r_arready & mem_axi_arvalid & ~r_rvalid;
            if (w_ar_hs) begin
                r_rvalid <= 1'b1;
                r_rdata  <= w_rd_data;
                r_rresp  <= w_rd_resp;
            end else if (r_rvalid && mem_axi_rready) begin
                r_rvalid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int unsigned i = 0; i < MSG_WORDS; i++) r_msg[i] <= '0;
        end else if (w_wr_exec) begin
            for (int unsigned i = 0; i < MSG_WORDS; i++) begin
                for (int unsigned b = 0; b < 4; b++) begin
                    if (w_msg_we[i] && r_wstrb[b]) r_msg[i][8*b +: 8] <= r_wdata[8*b +: 8];
                end
            end
        end
    end

    always_comb begin
        core_message = '0;
        for (int unsigned i = 0; i < MSG_WORDS; i++) begin
            core_message[32*(MSG_WORDS-1-i) +: 32] = r_msg[i];
        end
    end

    // r_cycles is 0 only in the first RUN cycle, which doubles as the "ignore core_ready" qualifier.
    assign w_cyc_next  = (r_cycles == '1) ? r_cycles : r_cycles + 32'd1;
    assign w_core_done = w_busy & core_ready & (r_cycles != '0);
    assign w_timeout   = w_busy & (TIMEOUT != 0) & (w_cyc_next == 32'(TIMEOUT));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_state <= S_IDLE;
        else         r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_start_cmd) w_next_state = S_RUN;
            S_RUN:   if (w_core_done || w_timeout) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_cycles     <= '0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_core_start <= 1'b0;
            for (int unsigned i = 0; i < HASH_WORDS; i++) r_hash[i] <= '0;
        end else begin
            r_core_start <= w_start_cmd;
            if (w_start_cmd) begin
                r_cycles <= '0;
                r_done   <= 1'b0;
                r_err    <= 1'b0;
            end else if (w_clr_cmd) begin
                r_done <= 1'b0;
                r_err  <= 1'b0;
            end
            if (w_busy) begin
                r_cycles <= w_cyc_next;
                if (w_core_done) begin
                    r_done <= 1'b1;
                    for (int unsigned i = 0; i < HASH_WORDS; i++) begin
                        r_hash[i] <= core_hash[32*(HASH_WORDS-1-i) +: 32];
                    end
                end else if (w_timeout) begin
                    r_err <= 1'b1;
                end
            end
        end
    end

`ifdef SHA_PERIPH_IRQ_EN
    logic r_irq_en, r_irq;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_irq_en <= 1'b0;
            r_irq    <= 1'b0;
        end else begin
            if (w_wr_exec && w_ctrl_we) r_irq_en <= r_wdata[2];
            if (w_start_cmd || w_clr_cmd) r_irq <= 1'b0;
            else                          r_irq <= r_irq_en & (r_done | r_err);
        end
    end

    assign irq         = r_irq;
    assign w_irq_en_rd = r_irq_en;
`else
    assign irq         = 1'b0;
    assign w_irq_en_rd = 1'b0;
`endif

endmodule

// File: tb/tb_axi4_sha256_periph.sv
`timescale 1ns/1ps
// Scoreboard bench for axi4_sha256_periph: expected B/R responses are queued by the
// stimulus tasks and checked by a monitor at each handshake.
module tb_axi4_sha256_periph;

    localparam logic [31:0]  BASE = 32'h3000_0000;
    localparam int           LAT  = 64;
    localparam logic [1:0]   OK   = 2'b00;
    localparam logic [1:0]   SLV  = 2'b10;
    localparam logic [1:0]   DEC  = 2'b11;
    localparam logic [255:0] H1   = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
    localparam logic [255:0] H2   = 256'h55555555_55555555_55555555_55555555_55555555_55555555_55555555_55555555;
`ifdef SHA_PERIPH_IRQ_EN
    localparam logic EXP_IRQ = 1'b1;
`else
    localparam logic EXP_IRQ = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         resetn;
    logic         awvalid, awready, wvalid, wready, bvalid, bready;
    logic         arvalid, arready, rvalid, rready;
    logic [31:0]  awaddr, wdata, araddr, rdata;
    logic [3:0]   wstrb;
    logic [1:0]   bresp, rresp;
    logic [511:0] core_message;
    logic         core_start, core_ready, irq;
    logic [255:0] core_hash;
    logic         ready_en;
    logic [31:0]  cnt = 32'd1000;
    int           n_start = 0;
    int           total = 0;
    int           bad = 0;

    typedef struct {
        logic [1:0]  resp;
        logic [31:0] data;
        string       name;
    } exp_t;
    exp_t exp_b[$];
    exp_t exp_r[$];

    always #5 clk = ~clk;

    axi4_sha256_periph #(
        .BASE_ADDR (BASE),
        .MSG_WORDS (16),
        .HASH_WORDS(8),
        .TIMEOUT   (1024)
    ) dut (
        .clk(clk), .resetn(resetn),
        .mem_axi_awvalid(awvalid), .mem_axi_awready(awready), .mem_axi_awaddr(awaddr), .mem_axi_awprot(3'b000),
        .mem_axi_wvalid(wvalid), .mem_axi_wready(wready), .mem_axi_wdata(wdata), .mem_axi_wstrb(wstrb),
        .mem_axi_bvalid(bvalid), .mem_axi_bready(bready), .mem_axi_bresp(bresp),
        .mem_axi_arvalid(arvalid), .mem_axi_arready(arready), .mem_axi_araddr(araddr), .mem_axi_arprot(3'b000),
        .mem_axi_rvalid(rvalid), .mem_axi_rready(rready), .mem_axi_rdata(rdata), .mem_axi_rresp(rresp),
        .core_message(core_message), .core_start(core_start), .core_ready(core_ready),
        .core_hash(core_hash), .irq(irq)
    );

    // Core model: ready level rises so that it is first sampled on the LAT-th RUN edge.
    // cnt starts high so core_ready is already 1 in the first RUN cycle of the first job.
    always @(posedge clk) begin
        if (core_start)                    cnt <= 32'd1;
        else if (cnt != 0 && cnt != '1)    cnt <= cnt + 32'd1;
    end
    assign core_ready = ready_en && (cnt >= 32'(LAT - 1));

    always @(negedge clk) if (core_start) n_start++;

    task automatic chk32(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (resetn && bvalid && bready) begin
            if (exp_b.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_b: bresp %b with nothing expected", bresp);
            end else begin
                e = exp_b.pop_front();
                chk32({e.name, "_bresp"}, {30'b0, bresp}, {30'b0, e.resp});
            end
        end
        if (resetn && rvalid && rready) begin
            if (exp_r.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_r: rdata %h with nothing expected", rdata);
            end else begin
                e = exp_r.pop_front();
                chk32({e.name, "_rresp"}, {30'b0, rresp}, {30'b0, e.resp});
                chk32({e.name, "_rdata"}, rdata, e.data);
            end
        end
    end

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                      input logic [1:0] er, input string nm,
                      input int adl = 0, input int wdl = 0, input int bdl = 0);
        exp_t e;
        int   na, nw;
        logic ha, hw, got;
        e.resp = er; e.data = '0; e.name = nm;
        exp_b.push_back(e);
        na = 0; nw = 0;
        for (int k = 0; k < 60 && (na == 0 || nw == 0); k++) begin
            if (k == adl) begin awvalid = 1'b1; awaddr = a; end
            if (k == wdl) begin wvalid = 1'b1; wdata = d; wstrb = s; end
            @(negedge clk);
            ha = awvalid && awready;
            hw = wvalid && wready;
            @(posedge clk); #1;
            if (ha) begin awvalid = 1'b0; na++; end
            if (hw) begin wvalid = 1'b0; nw++; end
        end
        total++;
        if (na != 1 || nw != 1) begin
            bad++;
            $display("FAIL %s_addr_data: aw=%0d w=%0d handshakes, required 1 each", nm, na, nw);
            awvalid = 1'b0; wvalid = 1'b0;
        end
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            if (bvalid) got = 1'b1;
            else begin @(posedge clk); #1; end
        end
        if (!got) begin
            total++; bad++;
            $display("FAIL %s_bvalid: got 0 within 20 cycles, required 1", nm);
            void'(exp_b.pop_back());
        end else begin
            for (int k = 0; k < bdl; k++) begin
                @(posedge clk); #1;
                chk32({nm, "_bhold"}, {31'b0, bvalid}, 32'd1);
            end
            bready = 1'b1;
            @(posedge clk); #1;
            bready = 1'b0;
            if (bdl > 0) chk32({nm, "_bdrop"}, {31'b0, bvalid}, 32'd0);
        end
    endtask

    task automatic rd(input logic [31:0] a, input logic [1:0] er, input logic [31:0] ed, input string nm);
        exp_t e;
        logic ha, got;
        e.resp = er; e.data = ed; e.name = nm;
        exp_r.push_back(e);
        arvalid = 1'b1; araddr = a;
        ha = 1'b0;
        for (int k = 0; k < 30 && arvalid; k++) begin
            @(negedge clk);
            ha = arvalid && arready;
            @(posedge clk); #1;
            if (ha) arvalid = 1'b0;
        end
        got = 1'b0;
        if (!arvalid) begin
            for (int k = 0; k < 20 && !got; k++) begin
                if (rvalid) got = 1'b1;
                else begin @(posedge clk); #1; end
            end
        end
        arvalid = 1'b0;
        if (!got) begin
            total++; bad++;
            $display("FAIL %s_rvalid: no read response within bound, required one", nm);
            void'(exp_r.pop_back());
        end else begin
            rready = 1'b1;
            @(posedge clk); #1;
            rready = 1'b0;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required finish");
        $fatal(1);
    end

    initial begin
        awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
        awaddr = '0; wdata = '0; wstrb = '0; araddr = '0;
        core_hash = H1; ready_en = 1'b1;
        resetn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk32("rst_awready", {31'b0, awready}, 32'd0);
        chk32("rst_wready",  {31'b0, wready},  32'd0);
        chk32("rst_arready", {31'b0, arready}, 32'd0);
        chk32("rst_bvalid",  {31'b0, bvalid},  32'd0);
        chk32("rst_rvalid",  {31'b0, rvalid},  32'd0);
        chk32("rst_resps",   {28'b0, bresp, rresp}, 32'd0);
        chk32("rst_rdata",   rdata, 32'd0);
        chk32("rst_start_irq", {30'b0, core_start, irq}, 32'd0);
        chk32("rst_msg_hi",  core_message[511:480], 32'd0);
        resetn = 1'b1;
        @(posedge clk); #1;

        rd(BASE + 32'h04, OK, 32'd0, "status_rst");
        rd(BASE + 32'h08, OK, 32'd0, "cycles_rst");

        wr(BASE + 32'h40, 32'h6162_6380, 4'hF, OK, "msg0_wr");
        wr(BASE + 32'h7C, 32'h0000_0018, 4'hF, OK, "msg15_wr");
        chk32("core_msg0",  core_message[511:480], 32'h6162_6380);
        chk32("core_msg15", core_message[31:0],    32'h0000_0018);

        wr(BASE, 32'h1, 4'hF, OK, "start1");
        rd(BASE + 32'h04, OK, 32'h1, "status_busy1");
        repeat (80) @(posedge clk);
        #1;
        rd(BASE + 32'h04, OK, 32'h2, "status_done");
        rd(BASE + 32'h08, OK, 32'd64, "cycles_done");
        rd(BASE + 32'h80, OK, 32'hba78_16bf, "hash0");
        rd(BASE + 32'h9C, OK, 32'hf200_15ad, "hash7");
        chk32("start_pulses1", n_start, 32'd1);

        wr(BASE + 32'h44, 32'h1111_2222, 4'hF, OK, "aw_first", 0, 3, 0);
        wr(BASE + 32'h48, 32'h3333_4444, 4'hF, OK, "w_first", 3, 0, 4);
        rd(BASE + 32'h44, OK, 32'h1111_2222, "msg1_rd");
        rd(BASE + 32'h48, OK, 32'h3333_4444, "msg2_rd");

        wr(BASE + 32'h4C, 32'hAABB_CCDD, 4'b0010, OK, "msg3_strb");
        rd(BASE + 32'h4C, OK, 32'h0000_CC00, "msg3_rd");
        chk32("core_msg3", core_message[415:384], 32'h0000_CC00);

        ready_en = 1'b0;
        core_hash = H2;
        wr(BASE, 32'h5, 4'hF, OK, "start2");
        wr(BASE + 32'h40, 32'hDEAD_BEEF, 4'hF, SLV, "msg_busy");
        rd(BASE + 32'h40, OK, 32'h6162_6380, "msg0_kept");
        wr(BASE, 32'h1, 4'hF, SLV, "start_busy");
        rd(BASE + 32'h80, OK, 32'hba78_16bf, "hash0_busy");
        rd(BASE + 32'h04, OK, 32'h1, "status_busy2");
        chk32("start_pulses2", n_start, 32'd2);
        repeat (1100) @(posedge clk);
        #1;
        rd(BASE + 32'h04, OK, 32'h4, "status_err");
        rd(BASE + 32'h08, OK, 32'd1024, "cycles_tmo");
        rd(BASE + 32'h80, OK, 32'hba78_16bf, "hash0_tmo");
        chk32("irq_err", {31'b0, irq}, {31'b0, EXP_IRQ});
        rd(BASE, OK, {29'b0, EXP_IRQ, 2'b00}, "ctrl_rd");
        wr(BASE, 32'h2, 4'hF, OK, "clr_done");
        repeat (2) @(posedge clk);
        #1;
        chk32("irq_clr", {31'b0, irq}, 32'd0);
        rd(BASE + 32'h04, OK, 32'h0, "status_clr");

        wr(BASE, 32'h1, 4'hE, OK, "ctrl_nostrb");
        rd(BASE + 32'h04, OK, 32'h0, "status_nostrb");
        chk32("start_pulses_nostrb", n_start, 32'd2);
        wr(BASE + 32'h04, 32'h0, 4'hF, SLV, "wr_status");
        wr(BASE + 32'h80, 32'h0, 4'hF, SLV, "wr_hash");
        wr(BASE + 32'hF0, 32'h0, 4'hF, DEC, "wr_unmapped");
        rd(BASE + 32'hF0, DEC, 32'h0, "rd_f0");
        rd(BASE + 32'h1000, DEC, 32'h0, "rd_1000");
        rd(BASE + 32'hA0, DEC, 32'h0, "rd_hash8");

        wr(BASE, 32'h1, 4'hF, OK, "start3");
        repeat (10) @(posedge clk);
        #1;
        chk32("start_pulses3", n_start, 32'd3);
        resetn = 1'b0;
        #2;
        chk32("midrst_msg0", core_message[511:480], 32'd0);
        chk32("midrst_outs", {27'b0, core_start, irq, bvalid, rvalid, awready}, 32'd0);
        @(posedge clk); #1;
        resetn = 1'b1;
        @(posedge clk); #1;
        rd(BASE + 32'h04, OK, 32'h0, "status_midrst");
        rd(BASE + 32'h08, OK, 32'h0, "cycles_midrst");
        rd(BASE + 32'h40, OK, 32'h0, "msg0_midrst");
        rd(BASE + 32'h80, OK, 32'h0, "hash0_midrst");
        repeat (3) @(posedge clk);
        #1;
        chk32("start_pulses_final", n_start, 32'd3);
        chk32("pending_responses", 32'(exp_b.size() + exp_r.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
